// File: rtl/vfdsu_pkg.sv
// Shared definitions for the VFDSU iteration/writeback controller.
//   - operand format encodings (FMT_H/S/D, 2'b11 reserved and run as half)
//   - controller state encoding
//   - rnd_of(): SRT round count for a format, given the per-format counts
package vfdsu_pkg;

    localparam logic [1:0] FMT_H = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_D = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ITER   = 2'b01,
        ST_EX3    = 2'b10,
        ST_WB_REQ = 2'b11
    } vfdsu_state_e;

    // Round counts are module parameters, so the caller hands them in.
    // The reserved encoding falls through to the half-precision count.
    function automatic int rnd_of(input logic [1:0] fmt,
                                  input int rnd_h,
                                  input int rnd_s,
                                  input int rnd_d);
        case (fmt)
            FMT_S:   return rnd_s;
            FMT_D:   return rnd_d;
            default: return rnd_h;
        endcase
    endfunction

endpackage

// File: rtl/ct_vfdsu_iter_cnt.sv
// Loadable SRT round down-counter.
// Ports:
//   forever_cpuclk, cpurst_b : clock, async active-low reset
//   cnt_clr                  : synchronous clear (flush), highest priority
//   cnt_load, load_val       : load the starting count (rounds - 1)
//   cnt_dec                  : decrement, saturating at zero
//   top_val                  : starting count of the op in flight
//   cnt                      : current count
//   cnt_zero                 : cnt == 0
//   cnt_top                  : cnt == top_val   (first round)
//   cnt_top_m1               : cnt == top_val-1 (second round)
module ct_vfdsu_iter_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             cnt_clr,
    input  logic             cnt_load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             cnt_dec,
    input  logic [CNT_W-1:0] top_val,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_zero,
    output logic             cnt_top,
    output logic             cnt_top_m1
);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_load) begin
            cnt <= load_val;
        end else if (cnt_dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Round counts are at least 2, so top_val - 1 never wraps.
    assign cnt_zero   = (cnt == '0);
    assign cnt_top    = (cnt == top_val);
    assign cnt_top_m1 = (cnt == (top_val - CNT_W'(1)));

endmodule

// File: rtl/ct_vfdsu_iter_ctrl.sv
// Iteration and writeback controller for the VFPU divide/sqrt unit.
// Sequences one op through ITER (SRT rounds), EX3 (rounding) and WB_REQ
// (writeback with backpressure), with a one-entry pending-issue buffer so
// the next op can be accepted while the current one is in flight.
// Handshakes: an op transfers on a cycle where issue_vld && issue_rdy;
// a result transfers on a cycle where wb_req && wb_grant. issue_rdy and
// wb_req are pure state decodes and never depend on the partner's signal.
// Ports:
//   forever_cpuclk, cpurst_b : clock, async active-low reset
//   rtu_yy_xx_flush          : synchronous kill of the op and pending entry
//   issue_vld/fmt/rdy        : op issue handshake and format
//   srt_skip, srt_rem_zero   : early-termination hints during ITER
//   wb_grant                 : writeback port granted
//   iter_on/first/secd/last  : iteration strobes to the SRT datapath
//   iter_fmt                 : format of the op in flight
//   ex3_vld, wb_req          : stage valids
//   busy, idle               : activity status for parent clock gating
//   dbg_state                : current FSM state, for observation
module ct_vfdsu_iter_ctrl
    import vfdsu_pkg::*;
#(
    parameter int CNT_W = 5,
    parameter int RND_D = 14,
    parameter int RND_S = 7,
    parameter int RND_H = 4
) (
    input  logic       forever_cpuclk,
    input  logic       cpurst_b,
    input  logic       rtu_yy_xx_flush,
    input  logic       issue_vld,
    input  logic [1:0] issue_fmt,
    output logic       issue_rdy,
    input  logic       srt_skip,
    input  logic       srt_rem_zero,
    input  logic       wb_grant,
    output logic       iter_on,
    output logic       iter_first,
    output logic       iter_secd,
    output logic       iter_last,
    output logic [1:0] iter_fmt,
    output logic       ex3_vld,
    output logic       wb_req,
    output logic       busy,
    output logic       idle,
    output logic [1:0] dbg_state
);

    vfdsu_state_e     state, state_nxt;
    logic [1:0]       cur_fmt;
    logic             pend_vld;
    logic [1:0]       pend_fmt;
    logic             first_q;

    logic             issue_acc;
    logic             load;
    logic [1:0]       load_fmt;
    logic             dec;
    logic             pend_set;
    logic             pend_clr;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] top_val;
    logic             cnt_zero;
    logic             cnt_top;
    logic             cnt_top_m1;

    // An issue in the flush cycle is dropped, so it never counts as accepted.
    assign issue_acc = issue_vld && !pend_vld && !rtu_yy_xx_flush;

    assign load_val = CNT_W'(rnd_of(load_fmt, RND_H, RND_S, RND_D) - 1);
    assign top_val  = CNT_W'(rnd_of(cur_fmt,  RND_H, RND_S, RND_D) - 1);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_fmt  = cur_fmt;
        dec       = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue_acc) begin
                    state_nxt = ST_ITER;
                    load      = 1'b1;
                    load_fmt  = issue_fmt;
                end
            end
            ST_ITER: begin
                if (iter_last) state_nxt = ST_EX3;
                else           dec       = 1'b1;
            end
            ST_EX3: begin
                state_nxt = ST_WB_REQ;
            end
            ST_WB_REQ: begin
                if (wb_grant) begin
                    if (pend_vld) begin
                        state_nxt = ST_ITER;
                        load      = 1'b1;
                        load_fmt  = pend_fmt;
                        pend_clr  = 1'b1;
                    end else if (issue_acc) begin
                        // Bypass: the issued op goes straight to ITER.
                        state_nxt = ST_ITER;
                        load      = 1'b1;
                        load_fmt  = issue_fmt;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Any accept outside IDLE parks in the buffer unless it was bypassed.
        if (issue_acc && (state != ST_IDLE) &&
            !((state == ST_WB_REQ) && wb_grant && !pend_vld)) begin
            pend_set = 1'b1;
        end

        if (rtu_yy_xx_flush) begin
            state_nxt = ST_IDLE;
            load      = 1'b0;
            dec       = 1'b0;
            pend_set  = 1'b0;
            pend_clr  = 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= ST_IDLE;
            cur_fmt  <= FMT_H;
            pend_vld <= 1'b0;
            pend_fmt <= FMT_H;
            first_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) cur_fmt <= load_fmt;
            if (rtu_yy_xx_flush || pend_clr) pend_vld <= 1'b0;
            else if (pend_set)               pend_vld <= 1'b1;
            if (pend_set) pend_fmt <= issue_fmt;
            // Remembers a first round that did not also end the op.
            first_q <= !rtu_yy_xx_flush && iter_first && !iter_last;
        end
    end

    ct_vfdsu_iter_cnt #(
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .cnt_clr        (rtu_yy_xx_flush),
        .cnt_load       (load),
        .load_val       (load_val),
        .cnt_dec        (dec),
        .top_val        (top_val),
        .cnt            (cnt),
        .cnt_zero       (cnt_zero),
        .cnt_top        (cnt_top),
        .cnt_top_m1     (cnt_top_m1)
    );

    assign iter_on    = (state == ST_ITER);
    assign iter_first = iter_on && cnt_top;
    assign iter_secd  = iter_on && cnt_top_m1 && first_q;
    assign iter_last  = iter_on && (cnt_zero || srt_rem_zero || srt_skip);
    assign iter_fmt   = cur_fmt;
    assign ex3_vld    = (state == ST_EX3);
    assign wb_req     = (state == ST_WB_REQ);
    assign busy       = (state != ST_IDLE) || pend_vld;
    assign idle       = !busy;
    assign issue_rdy  = !pend_vld;
    assign dbg_state  = state;

endmodule

// File: tb/tb_ct_vfdsu_iter_ctrl.sv
module tb_ct_vfdsu_iter_ctrl;

  localparam int CNT_W = 5;
  localparam int RND_D = 14;
  localparam int RND_S = 7;
  localparam int RND_H = 4;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       issue_vld;
  logic [1:0] issue_fmt;
  logic       issue_rdy;
  logic       srt_skip;
  logic       srt_rem_zero;
  logic       wb_grant;
  logic       iter_on;
  logic       iter_first;
  logic       iter_secd;
  logic       iter_last;
  logic [1:0] iter_fmt;
  logic       ex3_vld;
  logic       wb_req;
  logic       busy;
  logic       idle;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int rel    = 0;

  // Reference model: formats of accepted, not yet written-back ops in order.
  // Front entry is the op in flight, a second entry is the pending one.
  logic [1:0] exp_q[$];
  int         m_k   = 0;   // 1-based SRT round of the op in flight, 0 if none
  bit         m_ex3 = 0;
  bit         m_wb  = 0;

  ct_vfdsu_iter_ctrl #(
    .CNT_W (CNT_W),
    .RND_D (RND_D),
    .RND_S (RND_S),
    .RND_H (RND_H)
  ) dut (
    .forever_cpuclk  (clk),
    .cpurst_b        (rst_n),
    .rtu_yy_xx_flush (flush),
    .issue_vld       (issue_vld),
    .issue_fmt       (issue_fmt),
    .issue_rdy       (issue_rdy),
    .srt_skip        (srt_skip),
    .srt_rem_zero    (srt_rem_zero),
    .wb_grant        (wb_grant),
    .iter_on         (iter_on),
    .iter_first      (iter_first),
    .iter_secd       (iter_secd),
    .iter_last       (iter_last),
    .iter_fmt        (iter_fmt),
    .ex3_vld         (ex3_vld),
    .wb_req          (wb_req),
    .busy            (busy),
    .idle            (idle),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic int rnd_m(input logic [1:0] fmt);
    if (fmt == 2'b10) return RND_D;
    if (fmt == 2'b01) return RND_S;
    return RND_H;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_step();
    int sz0;
    bit acc;
    bit start;
    if (!rst_n || flush) begin
      m_k = 0; m_ex3 = 0; m_wb = 0;
      exp_q.delete();
      return;
    end
    sz0   = exp_q.size();
    acc   = issue_vld && (sz0 < 2);
    start = (sz0 == 0);
    if (m_k > 0) begin
      if (m_k == rnd_m(exp_q[0]) || srt_rem_zero || srt_skip) begin
        m_k = 0; m_ex3 = 1;
      end else begin
        m_k++;
      end
    end else if (m_ex3) begin
      m_ex3 = 0; m_wb = 1;
    end else if (m_wb && wb_grant) begin
      m_wb = 0;
      void'(exp_q.pop_front());
      start = 1;
    end
    if (acc) exp_q.push_back(issue_fmt);
    if (start && exp_q.size() > 0) m_k = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  task automatic compare_all();
    logic last_e;
    logic busy_e;
    busy_e = (exp_q.size() > 0);
    last_e = 1'b0;
    if (m_k > 0) last_e = (m_k == rnd_m(exp_q[0])) || srt_rem_zero || srt_skip;
    check("iter_on",    iter_on,    m_k > 0);
    check("iter_first", iter_first, m_k == 1);
    check("iter_secd",  iter_secd,  m_k == 2);
    check("iter_last",  iter_last,  last_e);
    check("ex3_vld",    ex3_vld,    m_ex3);
    check("wb_req",     wb_req,     m_wb);
    check("busy",       busy,       busy_e);
    check("idle",       idle,       !busy_e);
    check("issue_rdy",  issue_rdy,  exp_q.size() < 2);
    if (m_k > 0 || m_ex3 || m_wb) check("iter_fmt", iter_fmt, exp_q[0]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic adv();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic upto(input int n);
    while (rel < n) adv();
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush = 0; issue_vld = 0; issue_fmt = 2'b00;
    srt_skip = 0; srt_rem_zero = 0; wb_grant = 1;
  endtask

  task automatic drain();
    int n;
    clear_inputs();
    n = 0;
    adv();
    while (!idle && n < 100) begin adv(); n++; end
    check("drain_idle", idle, 1);
    adv();
  endtask

  task automatic start_op(input logic [1:0] fmt);
    rel = 0;
    issue_vld = 1; issue_fmt = fmt;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    look();
    check("rst_idle",  idle, 1);
    check("rst_busy",  busy, 0);
    check("rst_rdy",   issue_rdy, 1);
    check("rst_fmt",   iter_fmt, 2'b00);
    check("rst_wbreq", wb_req, 0);
    @(posedge clk); #1;
    rst_n = 1;
    adv();

    // Double, full length, immediate grant
    start_op(2'b10); adv(); issue_vld = 0;
    look(); check("d_first", iter_first, 1);
    upto(2);  look(); check("d_secd", iter_secd, 1);
    upto(14); look(); check("d_last", iter_last, 1);
    upto(15); look(); check("d_ex3", ex3_vld, 1);
    upto(16); look(); check("d_wbreq", wb_req, 1);
    upto(17); look(); check("d_idle", idle, 1);
    drain();

    // Single, remainder zero on round 3
    start_op(2'b01); adv(); issue_vld = 0;
    upto(3); srt_rem_zero = 1;
    look(); check("s_last3", iter_last, 1);
    adv(); srt_rem_zero = 0;
    look(); check("s_ex3", ex3_vld, 1);
    upto(5); look(); check("s_wbreq", wb_req, 1);
    drain();

    // Half, skip on first round
    start_op(2'b00); adv(); issue_vld = 0; srt_skip = 1;
    look(); check("h_first", iter_first, 1); check("h_last", iter_last, 1);
    adv(); srt_skip = 0;
    look(); check("h_secd", iter_secd, 0);
    upto(3); look(); check("h_wbreq", wb_req, 1);
    drain();

    // Back-to-back with pending entry and a stalled third issue
    start_op(2'b01); adv(); issue_vld = 0;
    upto(2); issue_vld = 1; issue_fmt = 2'b10;
    adv(); issue_fmt = 2'b00;
    look(); check("b_rdy3", issue_rdy, 0);
    upto(9); look(); check("b_wbreq9", wb_req, 1);
    upto(10); look();
    check("b_first10", iter_first, 1);
    check("b_fmt10", iter_fmt, 2'b10);
    check("b_rdy10", issue_rdy, 1);
    adv(); issue_vld = 0;
    look(); check("b_rdy11", issue_rdy, 0);
    drain();

    // Grant withheld five cycles with a pending single
    wb_grant = 0;
    start_op(2'b00); adv(); issue_vld = 0;
    upto(2); issue_vld = 1; issue_fmt = 2'b01;
    adv(); issue_vld = 0;
    upto(6); look(); check("g_wbreq6", wb_req, 1);
    upto(10); look();
    check("g_wbreq10", wb_req, 1);
    check("g_busy10", busy, 1);
    check("g_rdy10", issue_rdy, 0);
    check("g_fmt10", iter_fmt, 2'b00);
    upto(11); wb_grant = 1;
    look(); check("g_wbreq11", wb_req, 1);
    adv(); look();
    check("g_first12", iter_first, 1);
    check("g_fmt12", iter_fmt, 2'b01);
    drain();

    // Flush mid-ITER with pending valid and a same-cycle issue
    start_op(2'b10); adv(); issue_vld = 0;
    upto(2); issue_vld = 1; issue_fmt = 2'b01;
    adv(); issue_vld = 0;
    upto(5); flush = 1; issue_vld = 1; issue_fmt = 2'b10;
    adv(); flush = 0; issue_vld = 0;
    look();
    check("f_idle", idle, 1);
    check("f_rdy", issue_rdy, 1);
    for (int i = 0; i < 20; i++) begin
      adv(); look();
      check("f_no_ex3", ex3_vld, 0);
      check("f_no_wb", wb_req, 0);
    end
    drain();

    // Asynchronous reset mid-op
    start_op(2'b10); adv(); issue_vld = 0;
    upto(4); #1; rst_n = 0; #1;
    check("r_iter_on", iter_on, 0);
    check("r_idle", idle, 1);
    check("r_rdy", issue_rdy, 1);
    @(posedge clk); #1; rst_n = 1;
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      issue_vld    = ($urandom_range(0, 99) < 40);
      issue_fmt    = 2'($urandom_range(0, 3));
      srt_rem_zero = ($urandom_range(0, 99) < 5);
      srt_skip     = ($urandom_range(0, 99) < 3);
      wb_grant     = ($urandom_range(0, 99) < 60);
      flush        = ($urandom_range(0, 199) < 3);
      adv();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
